intr_controller: RTL and testbench

//  Memory-mapped priority interrupt controller for the I/O bus (ABUS/DBUS/WE).
//  - Collects INTR lines from peripheral devices (keys, switches, timer) and raises one IRQ to the CPU.
//  - Sequences acknowledge and end-of-interrupt (EOI) so one interrupt is in service at a time.
//  - Mapped on the same bus as the devices; read data is tri-stated onto DBUS.

---
 rtl/intr_controller.sv | 135 +++++++++++++
 tb/tb_intr_controller.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_controller.sv
// Memory-mapped priority interrupt controller: latches INTR_IN rising edges, raises IRQ
// for the lowest-index enabled source and sequences IACK / EOI so one source is in service.
module intr_controller #(
  parameter int unsigned       WBITS = 32,
  parameter int unsigned       NDEV  = 4,
  parameter logic [WBITS-1:0]  BASE  = 32'hF000_0100
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WBITS-1:0] ABUS,
  inout  wire  [WBITS-1:0] DBUS,
  input  logic             WE,
  input  logic [NDEV-1:0]  INTR_IN,
  input  logic             IACK,
  output logic             IRQ
);

  localparam int unsigned      IDW    = $clog2(NDEV);
  localparam logic [WBITS-1:0] A_PEND = BASE;
  localparam logic [WBITS-1:0] A_MASK = BASE + WBITS'(4);
  localparam logic [WBITS-1:0] A_EOI  = BASE + WBITS'(12);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_SERVICE
  } state_t;

  state_t          state, state_nx;
  logic [NDEV-1:0] pend, pend_nx;
  logic [NDEV-1:0] mask;
  logic [NDEV-1:0] prev;
  logic [NDEV-1:0] elig, rise, clr;
  logic [IDW-1:0]  vec_id, vec_id_nx, winner;
  logic            vec_flag, vec_flag_nx;
  logic            grant;
  logic            wr_pend, wr_mask, wr_eoi;
  logic            rd_hit;
  logic [WBITS-1:0] rd_data;
  logic            unused_dbus_hi;

  assign wr_pend = WE && (ABUS == A_PEND);
  assign wr_mask = WE && (ABUS == A_MASK);
  assign wr_eoi  = WE && (ABUS == A_EOI);

  assign elig = pend & mask;
  assign rise = INTR_IN & ~prev;

  // Lowest index wins: scan from the top so the last hit is the smallest index.
  always_comb begin
    winner = '0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (elig[NDEV-1-i]) winner = IDW'(NDEV-1-i);
    end
  end

  always_comb begin
    state_nx    = state;
    grant       = 1'b0;
    vec_id_nx   = vec_id;
    vec_flag_nx = vec_flag;
    case (state)
      S_IDLE: begin
        if (|elig) state_nx = S_REQ;
      end
      S_REQ: begin
        if (~|elig) begin
          state_nx = S_IDLE;
        end else if (IACK) begin
          state_nx    = S_SERVICE;
          grant       = 1'b1;
          vec_id_nx   = winner;
          vec_flag_nx = 1'b1;
        end
      end
      S_SERVICE: begin
        if (wr_eoi) begin
          state_nx    = S_IDLE;
          vec_flag_nx = 1'b0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // A new edge in the same cycle as a clear keeps the bit set.
  always_comb begin
    clr = '0;
    if (wr_pend) clr = DBUS[NDEV-1:0];
    if (grant)   clr = clr | (NDEV'(1) << winner);
    pend_nx = (pend & ~clr) | rise;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      pend     <= '0;
      mask     <= '0;
      prev     <= '0;
      vec_id   <= '0;
      vec_flag <= 1'b0;
      IRQ      <= 1'b0;
    end else begin
      state    <= state_nx;
      pend     <= pend_nx;
      prev     <= INTR_IN;
      vec_id   <= vec_id_nx;
      vec_flag <= vec_flag_nx;
      IRQ      <= (state_nx == S_REQ);
      if (wr_mask) mask <= DBUS[NDEV-1:0];
    end
  end

  // The whole 16-byte window claims reads; misaligned or EOI reads return zero.
  always_comb begin
    rd_hit  = !WE && (ABUS[WBITS-1:4] == BASE[WBITS-1:4]);
    rd_data = '0;
    if (ABUS[1:0] == 2'b00) begin
      case (ABUS[3:2])
        2'd0: rd_data[NDEV-1:0] = pend;
        2'd1: rd_data[NDEV-1:0] = mask;
        2'd2: begin
          rd_data[IDW-1:0] = vec_id;
          rd_data[8]       = vec_flag;
        end
        default: rd_data = '0;
      endcase
    end
  end

  assign DBUS = rd_hit ? rd_data : 'z;

  assign unused_dbus_hi = ^DBUS[WBITS-1:NDEV];

endmodule

// File: tb/tb_intr_controller.sv
// Self-checking bench for intr_controller: directed scenarios plus a randomized run
// checked against a register-level reference model.
module tb_intr_controller;

  localparam logic [31:0] BASE   = 32'hF000_0100;
  localparam logic [31:0] A_PEND = BASE;
  localparam logic [31:0] A_MASK = BASE + 32'd4;
  localparam logic [31:0] A_VEC  = BASE + 32'd8;
  localparam logic [31:0] A_EOI  = BASE + 32'd12;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ABUS;
  wire  [31:0] DBUS;
  logic        WE;
  logic [3:0]  INTR_IN;
  logic        IACK;
  logic        IRQ;

  logic [31:0] tb_d;
  logic        tb_drv;

  int passed = 0;
  int total  = 0;

  // Reference model state: only the architecturally visible registers.
  logic [3:0] m_pend, m_mask, m_prev, m_vid;
  logic       m_vflag, m_irq;

  assign DBUS = tb_drv ? tb_d : 'z;

  always #5 CLK = ~CLK;

  intr_controller #(.WBITS(32), .NDEV(4), .BASE(32'hF000_0100)) dut (
    .CLK(CLK), .RESET(RESET), .ABUS(ABUS), .DBUS(DBUS), .WE(WE),
    .INTR_IN(INTR_IN), .IACK(IACK), .IRQ(IRQ)
  );

  function automatic logic [31:0] m_vec();
    return {23'h0, m_vflag, 4'h0, m_vid};
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0; m_vid = '0; m_vflag = 1'b0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] elig, clr, rise;
    int         w;
    bit         eoi;
    elig = m_pend & m_mask;
    w = 0;
    for (int i = 3; i >= 0; i--) if (elig[i]) w = i;
    clr  = (WE && ABUS == A_PEND) ? tb_d[3:0] : 4'h0;
    eoi  = WE && (ABUS == A_EOI);
    rise = INTR_IN & ~m_prev;
    if (m_vflag) begin
      if (eoi) m_vflag = 1'b0;
      m_irq = 1'b0;
    end else if (m_irq) begin
      if (elig == 0) m_irq = 1'b0;
      else if (IACK) begin
        m_vid = 4'(w); m_vflag = 1'b1; clr[w] = 1'b1; m_irq = 1'b0;
      end
    end else begin
      m_irq = (elig != 0);
    end
    if (WE && ABUS == A_MASK) m_mask = tb_d[3:0];
    m_pend = (m_pend & ~clr) | rise;
    m_prev = INTR_IN;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    WE = 1'b0; IACK = 1'b0; tb_drv = 1'b0; ABUS = '0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    ABUS = addr; tb_d = data; WE = 1'b1; tb_drv = 1'b1;
    tick();
  endtask

  task automatic pulse_iack();
    IACK = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; model_reset();
    #2;
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1; WE = 1'b0; IACK = 1'b0; INTR_IN = '0; ABUS = '0; tb_d = '0; tb_drv = 1'b0;
    model_reset();
    #3;
    total++; if (IRQ !== 1'b0) $display("FAIL reset_irq got %b want 0", IRQ); else passed++;
    for (int k = 0; k < 4; k++) begin
      ABUS = BASE + 32'(4 * k); #1;
      total++;
      if (DBUS !== 32'h0) $display("FAIL reset_reg%0d got %h want 0", k, DBUS); else passed++;
    end
    RESET = 1'b0;
    @(negedge CLK);
    // Bench drives a pattern on an unselected address: any DUT drive would corrupt it.
    tb_d = 32'hA5A5_5A5A; tb_drv = 1'b1;
    ABUS = 32'h0000_1000; #1;
    total++; if (DBUS !== 32'hA5A5_5A5A) $display("FAIL z_unmapped got %h want a5a55a5a", DBUS); else passed++;
    ABUS = BASE + 32'd16; #1;
    total++; if (DBUS !== 32'hA5A5_5A5A) $display("FAIL z_above got %h want a5a55a5a", DBUS); else passed++;
    tb_drv = 1'b0; ABUS = '0;
  endtask

  task automatic test_single();
    bus_write(A_MASK, 32'hF);
    INTR_IN = 4'b0100;
    tick();
    ABUS = A_PEND; #1;
    total++; if (DBUS !== 32'h4) $display("FAIL t1_pend got %h want 4", DBUS); else passed++;
    total++; if (IRQ !== 1'b0) $display("FAIL t1_irq_early got %b want 0", IRQ); else passed++;
    tick();
    total++; if (IRQ !== 1'b1) $display("FAIL t1_irq got %b want 1", IRQ); else passed++;
    INTR_IN = 4'b0000;
    pulse_iack();
    ABUS = A_VEC; #1;
    total++; if (DBUS !== 32'h102) $display("FAIL t1_vec got %h want 102", DBUS); else passed++;
    ABUS = A_PEND; #1;
    total++; if (DBUS !== 32'h0) $display("FAIL t1_pend_clr got %h want 0", DBUS); else passed++;
    total++; if (IRQ !== 1'b0) $display("FAIL t1_irq_drop got %b want 0", IRQ); else passed++;
    bus_write(A_EOI, 32'h0);
  endtask

  task automatic test_priority();
    INTR_IN = 4'b1010;
    tick(); tick();
    total++; if (IRQ !== 1'b1) $display("FAIL t2_irq got %b want 1", IRQ); else passed++;
    pulse_iack();
    ABUS = A_VEC; #1;
    total++; if (DBUS !== 32'h101) $display("FAIL t2_vec1 got %h want 101", DBUS); else passed++;
    ABUS = A_PEND; #1;
    total++; if (DBUS !== 32'h8) $display("FAIL t2_pend got %h want 8", DBUS); else passed++;
    bus_write(A_EOI, 32'h1234);
    total++; if (IRQ !== 1'b0) $display("FAIL t2_irq_eoi got %b want 0", IRQ); else passed++;
    tick();
    total++; if (IRQ !== 1'b1) $display("FAIL t2_irq_reassert got %b want 1", IRQ); else passed++;
    pulse_iack();
    ABUS = A_VEC; #1;
    total++; if (DBUS !== 32'h103) $display("FAIL t2_vec3 got %h want 103", DBUS); else passed++;
    bus_write(A_EOI, 32'h0);
    INTR_IN = 4'b0000;
    tick();
  endtask

  task automatic test_mask();
    bus_write(A_MASK, 32'hE);
    INTR_IN = 4'b0001;
    tick();
    ABUS = A_PEND; #1;
    total++; if (DBUS !== 32'h1) $display("FAIL t3_pend got %h want 1", DBUS); else passed++;
    tick(); tick();
    total++; if (IRQ !== 1'b0) $display("FAIL t3_masked_irq got %b want 0", IRQ); else passed++;
    bus_write(A_MASK, 32'hF);
    ABUS = A_MASK; #1;
    total++; if (DBUS !== 32'hF) $display("FAIL t3_mask got %h want f", DBUS); else passed++;
    tick();
    total++; if (IRQ !== 1'b1) $display("FAIL t3_unmask_irq got %b want 1", IRQ); else passed++;
    pulse_iack();
    ABUS = A_VEC; #1;
    total++; if (DBUS !== 32'h100) $display("FAIL t3_vec got %h want 100", DBUS); else passed++;
    bus_write(A_EOI, 32'h0);
    INTR_IN = 4'b0000;
    tick();
  endtask

  task automatic test_w1c_cancel();
    INTR_IN = 4'b0100;
    tick(); tick();
    total++; if (IRQ !== 1'b1) $display("FAIL t4_irq got %b want 1", IRQ); else passed++;
    bus_write(A_PEND, 32'h4);
    tick();
    total++; if (IRQ !== 1'b0) $display("FAIL t4_irq_cancel got %b want 0", IRQ); else passed++;
    pulse_iack();
    ABUS = A_VEC; #1;
    total++; if (DBUS !== 32'h000) $display("FAIL t4_vec_hold got %h want 0", DBUS); else passed++;
    total++; if (IRQ !== 1'b0) $display("FAIL t4_late_iack_irq got %b want 0", IRQ); else passed++;
    INTR_IN = 4'b0000;
    tick();
  endtask

  task automatic test_no_nesting();
    INTR_IN = 4'b0100;
    tick(); tick();
    pulse_iack();
    INTR_IN = 4'b0101;
    tick();
    ABUS = A_PEND; #1;
    total++; if (DBUS !== 32'h1) $display("FAIL t5_pend got %h want 1", DBUS); else passed++;
    tick();
    total++; if (IRQ !== 1'b0) $display("FAIL t5_irq_service got %b want 0", IRQ); else passed++;
    pulse_iack();
    ABUS = A_VEC; #1;
    total++; if (DBUS !== 32'h102) $display("FAIL t5_vec_stray got %h want 102", DBUS); else passed++;
    bus_write(A_EOI, 32'h0);
    tick();
    total++; if (IRQ !== 1'b1) $display("FAIL t5_irq_after_eoi got %b want 1", IRQ); else passed++;
    pulse_iack();
    bus_write(A_EOI, 32'h0);
    bus_write(A_EOI, 32'h0);
    ABUS = A_VEC; #1;
    total++; if (DBUS !== 32'h000) $display("FAIL t5_vec_idle_eoi got %h want 0", DBUS); else passed++;
    total++; if (IRQ !== 1'b0) $display("FAIL t5_irq_idle got %b want 0", IRQ); else passed++;
    INTR_IN = 4'b0000;
    tick();
  endtask

  task automatic test_reset_in_service();
    INTR_IN = 4'b0001;
    tick(); tick();
    pulse_iack();
    INTR_IN = 4'b0011;
    tick();
    ABUS = A_PEND; #1;
    total++; if (DBUS !== 32'h2) $display("FAIL t6_pend_pre got %h want 2", DBUS); else passed++;
    RESET = 1'b1; model_reset(); INTR_IN = 4'b0000;
    #1;
    total++; if (IRQ !== 1'b0) $display("FAIL t6_irq got %b want 0", IRQ); else passed++;
    for (int k = 0; k < 4; k++) begin
      ABUS = BASE + 32'(4 * k); #1;
      total++;
      if (DBUS !== 32'h0) $display("FAIL t6_reg%0d got %h want 0", k, DBUS); else passed++;
    end
    @(negedge CLK);
    RESET = 1'b0;
    tick();
    total++; if (IRQ !== 1'b0) $display("FAIL t6_irq_post got %b want 0", IRQ); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] exp, addr;
    int          op;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) INTR_IN = 4'($urandom);
      IACK = ($urandom_range(0, 3) == 0);
      op = int'($urandom_range(0, 11));
      if (op == 8) begin
        ABUS = A_MASK; tb_d = $urandom; WE = 1'b1; tb_drv = 1'b1;
      end else if (op == 9) begin
        ABUS = A_PEND; tb_d = $urandom; WE = 1'b1; tb_drv = 1'b1;
      end else if (op >= 10) begin
        ABUS = A_EOI; tb_d = $urandom; WE = 1'b1; tb_drv = 1'b1;
      end else begin
        addr = BASE + 32'(4 * (op % 4));
        ABUS = addr; #1;
        case (op % 4)
          0:       exp = {28'h0, m_pend};
          1:       exp = {28'h0, m_mask};
          2:       exp = m_vec();
          default: exp = 32'h0;
        endcase
        total++;
        if (DBUS !== exp) $display("FAIL rnd_read c=%0d addr=%h got %h want %h", c, addr, DBUS, exp);
        else passed++;
      end
      tick();
      total++;
      if (IRQ !== m_irq) $display("FAIL rnd_irq c=%0d got %b want %b", c, IRQ, m_irq);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_w1c_cancel();
    test_no_nesting();
    test_reset_in_service();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
